// File: rtl/ula_fatiada.sv
// Multi-cycle 74181-style ALU: evaluates one 4-bit slice per clock, LSB first,
// rippling the slice carry through a register so WIDTH-bit results match a cascade.
module ula_fatiada #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [3:0]       s,
  input  logic             m,
  input  logic             c_in,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] f,
  output logic             c_out,
  output logic             a_eq_b,
  output logic             zero
);
  localparam int N  = WIDTH / 4;
  localparam int IW = (N > 1) ? $clog2(N) : 1;
  localparam logic [IW-1:0] LAST_IDX = IW'(N - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state_reg, state_next;
  logic [WIDTH-1:0] a_reg, b_reg;
  logic [WIDTH-1:0] res_reg, res_next;
  logic [3:0]       s_reg;
  logic             m_reg;
  logic             carry_reg;
  logic [IW-1:0]    idx_reg;

  logic             capture, step, last;
  logic [3:0]       slice_a, slice_b;
  logic [3:0]       x_op, y_op, logic_f, slice_f;
  logic [4:0]       sum5;
  logic             slice_carry;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    in_ready   = 1'b0;
    out_valid  = 1'b0;
    capture    = 1'b0;
    step       = 1'b0;
    last       = 1'b0;
    case (state_reg)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) begin
          capture    = 1'b1;
          state_next = RUN;
        end
      end
      RUN: begin
        step = 1'b1;
        if (idx_reg == LAST_IDX) begin
          last       = 1'b1;
          state_next = DONE;
        end
      end
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) begin
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // Slice views of the captured operands, selected by the running slice index.
  logic [3:0] a_sl [N];
  logic [3:0] b_sl [N];

  genvar gi;
  generate
    for (gi = 0; gi < N; gi++) begin : g_slice_src
      assign a_sl[gi] = a_reg[4*gi +: 4];
      assign b_sl[gi] = b_reg[4*gi +: 4];
    end
  endgenerate

  assign slice_a = a_sl[idx_reg];
  assign slice_b = b_sl[idx_reg];

  always_comb begin
    x_op = slice_a;
    y_op = 4'h0;
    case (s_reg)
      4'd0:  begin x_op = slice_a;             y_op = 4'h0;              end
      4'd1:  begin x_op = slice_a | slice_b;   y_op = 4'h0;              end
      4'd2:  begin x_op = slice_a | ~slice_b;  y_op = 4'h0;              end
      4'd3:  begin x_op = 4'hF;                y_op = 4'h0;              end
      4'd4:  begin x_op = slice_a;             y_op = slice_a & ~slice_b; end
      4'd5:  begin x_op = slice_a | slice_b;   y_op = slice_a & ~slice_b; end
      4'd6:  begin x_op = slice_a;             y_op = ~slice_b;          end
      4'd7:  begin x_op = slice_a & ~slice_b;  y_op = 4'hF;              end
      4'd8:  begin x_op = slice_a;             y_op = slice_a & slice_b; end
      4'd9:  begin x_op = slice_a;             y_op = slice_b;           end
      4'd10: begin x_op = slice_a | ~slice_b;  y_op = slice_a & slice_b; end
      4'd11: begin x_op = slice_a & slice_b;   y_op = 4'hF;              end
      4'd12: begin x_op = slice_a;             y_op = slice_a;           end
      4'd13: begin x_op = slice_a | slice_b;   y_op = slice_a;           end
      4'd14: begin x_op = slice_a | ~slice_b;  y_op = slice_a;           end
      default: begin x_op = slice_a;           y_op = 4'hF;              end
    endcase
    sum5 = {1'b0, x_op} + {1'b0, y_op} + {4'b0000, carry_reg};
  end

  always_comb begin
    logic_f = 4'h0;
    case (s_reg)
      4'd0:  logic_f = ~slice_a;
      4'd1:  logic_f = ~(slice_a | slice_b);
      4'd2:  logic_f = ~slice_a & slice_b;
      4'd3:  logic_f = 4'h0;
      4'd4:  logic_f = ~(slice_a & slice_b);
      4'd5:  logic_f = ~slice_b;
      4'd6:  logic_f = slice_a ^ slice_b;
      4'd7:  logic_f = slice_a & ~slice_b;
      4'd8:  logic_f = ~slice_a | slice_b;
      4'd9:  logic_f = ~(slice_a ^ slice_b);
      4'd10: logic_f = slice_b;
      4'd11: logic_f = slice_a & slice_b;
      4'd12: logic_f = 4'hF;
      4'd13: logic_f = slice_a | ~slice_b;
      4'd14: logic_f = slice_a | slice_b;
      default: logic_f = slice_a;
    endcase
  end

  assign slice_f     = m_reg ? logic_f : sum5[3:0];
  assign slice_carry = m_reg ? 1'b0 : sum5[4];

  // Merge the current slice into the result so the final load sees all N slices.
  generate
    for (gi = 0; gi < N; gi++) begin : g_res_merge
      assign res_next[4*gi +: 4] = (step && (idx_reg == IW'(gi))) ? slice_f
                                                                   : res_reg[4*gi +: 4];
    end
  endgenerate

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_reg     <= '0;
      b_reg     <= '0;
      s_reg     <= 4'h0;
      m_reg     <= 1'b0;
      carry_reg <= 1'b0;
      idx_reg   <= '0;
      res_reg   <= '0;
      f         <= '0;
      c_out     <= 1'b0;
      a_eq_b    <= 1'b0;
      zero      <= 1'b0;
    end else begin
      if (capture) begin
        a_reg     <= a;
        b_reg     <= b;
        s_reg     <= s;
        m_reg     <= m;
        carry_reg <= c_in;
        idx_reg   <= '0;
        res_reg   <= '0;
      end
      if (step) begin
        res_reg   <= res_next;
        carry_reg <= slice_carry;
        if (!last) begin
          idx_reg <= idx_reg + 1'b1;
        end
      end
      if (last) begin
        f      <= res_next;
        c_out  <= slice_carry;
        a_eq_b <= (a_reg == b_reg);
        zero   <= (res_next == '0);
      end
    end
  end

endmodule

// File: tb/tb_ula_fatiada.sv
// Directed and randomized checks of ula_fatiada against a full-width reference model.
module tb_ula_fatiada;
  localparam int WIDTH = 16;
  localparam int N     = WIDTH / 4;

  logic             clk       = 1'b0;
  logic             rst_n     = 1'b0;
  logic             in_valid  = 1'b0;
  logic             in_ready;
  logic [WIDTH-1:0] a         = '0;
  logic [WIDTH-1:0] b         = '0;
  logic [3:0]       s         = 4'h0;
  logic             m         = 1'b0;
  logic             c_in      = 1'b0;
  logic             out_valid;
  logic             out_ready = 1'b0;
  logic [WIDTH-1:0] f;
  logic             c_out;
  logic             a_eq_b;
  logic             zero;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  ula_fatiada #(.WIDTH(WIDTH)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .s         (s),
    .m         (m),
    .c_in      (c_in),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .f         (f),
    .c_out     (c_out),
    .a_eq_b    (a_eq_b),
    .zero      (zero)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Whole-word function: {carry, result}; logic mode never produces a carry.
  function automatic logic [WIDTH:0] ref_alu(input logic [WIDTH-1:0] ra, input logic [WIDTH-1:0] rb,
                                             input logic [3:0] rs, input logic rm, input logic rc);
    logic [WIDTH-1:0] x, y, r, k;
    k = '1; x = '0; y = '0; r = '0;
    if (rm) begin
      case (rs)
        4'd0:  r = ~ra;
        4'd1:  r = ~(ra | rb);
        4'd2:  r = ~ra & rb;
        4'd3:  r = '0;
        4'd4:  r = ~(ra & rb);
        4'd5:  r = ~rb;
        4'd6:  r = ra ^ rb;
        4'd7:  r = ra & ~rb;
        4'd8:  r = ~ra | rb;
        4'd9:  r = ~(ra ^ rb);
        4'd10: r = rb;
        4'd11: r = ra & rb;
        4'd12: r = '1;
        4'd13: r = ra | ~rb;
        4'd14: r = ra | rb;
        default: r = ra;
      endcase
      return {1'b0, r};
    end
    case (rs)
      4'd0:  begin x = ra;        y = '0;       end
      4'd1:  begin x = ra | rb;   y = '0;       end
      4'd2:  begin x = ra | ~rb;  y = '0;       end
      4'd3:  begin x = k;         y = '0;       end
      4'd4:  begin x = ra;        y = ra & ~rb; end
      4'd5:  begin x = ra | rb;   y = ra & ~rb; end
      4'd6:  begin x = ra;        y = ~rb;      end
      4'd7:  begin x = ra & ~rb;  y = k;        end
      4'd8:  begin x = ra;        y = ra & rb;  end
      4'd9:  begin x = ra;        y = rb;       end
      4'd10: begin x = ra | ~rb;  y = ra & rb;  end
      4'd11: begin x = ra & rb;   y = k;        end
      4'd12: begin x = ra;        y = ra;       end
      4'd13: begin x = ra | rb;   y = ra;       end
      4'd14: begin x = ra | ~rb;  y = ra;       end
      default: begin x = ra;      y = k;        end
    endcase
    return {1'b0, x} + {1'b0, y} + {{WIDTH{1'b0}}, rc};
  endfunction

  task automatic chk_reset_outputs(input string tag);
    chk({tag, ".in_ready"},  32'(in_ready),  32'd1);
    chk({tag, ".out_valid"}, 32'(out_valid), 32'd0);
    chk({tag, ".f"},         32'(f),         32'd0);
    chk({tag, ".c_out"},     32'(c_out),     32'd0);
    chk({tag, ".a_eq_b"},    32'(a_eq_b),    32'd0);
    chk({tag, ".zero"},      32'(zero),      32'd0);
  endtask

  // Called #1 after a rising edge with the DUT idle; returns #1 after the last edge used.
  task automatic do_op(input string tag, input logic [WIDTH-1:0] ta, input logic [WIDTH-1:0] tb2,
                       input logic [3:0] ts, input logic tm, input logic tc, input bit release_it);
    logic [WIDTH:0] exp;
    int cyc;
    exp = ref_alu(ta, tb2, ts, tm, tc);
    chk({tag, ".in_ready"}, 32'(in_ready), 32'd1);
    a = ta; b = tb2; s = ts; m = tm; c_in = tc; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    a = WIDTH'($urandom);
    b = WIDTH'($urandom);
    s = 4'($urandom);
    m = 1'($urandom);
    c_in = 1'($urandom);
    cyc = 0;
    while (!out_valid && cyc < 20) begin
      @(posedge clk); #1;
      cyc++;
    end
    chk({tag, ".latency"}, 32'(cyc),    32'(N));
    chk({tag, ".f"},       32'(f),      32'(exp[WIDTH-1:0]));
    chk({tag, ".c_out"},   32'(c_out),  32'(exp[WIDTH]));
    chk({tag, ".a_eq_b"},  32'(a_eq_b), 32'(ta == tb2));
    chk({tag, ".zero"},    32'(zero),   32'(exp[WIDTH-1:0] == '0));
    $display("op %s: a=%h b=%h s=%0d m=%0d c_in=%0d -> f=%h c_out=%0d eq=%0d zero=%0d",
             tag, ta, tb2, ts, tm, tc, f, c_out, a_eq_b, zero);
    if (release_it) begin
      out_ready = 1'b1;
      @(posedge clk); #1;
      out_ready = 1'b0;
    end
  endtask

  initial begin
    logic [WIDTH:0] bp_exp;

    #2;
    chk_reset_outputs("por");
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;

    do_op("add_ovf", 16'hFFFF, 16'h0001, 4'b1001, 1'b0, 1'b0, 1'b1);
    chk("add_ovf.f_const", 32'(f), 32'h0000);
    chk("add_ovf.c_const", 32'(c_out), 32'd1);

    do_op("sub_c1", 16'h1234, 16'h1234, 4'b0110, 1'b0, 1'b1, 1'b1);
    chk("sub_c1.f_const", 32'(f), 32'h0000);
    do_op("sub_c0", 16'h1234, 16'h1234, 4'b0110, 1'b0, 1'b0, 1'b0);
    chk("sub_c0.f_const", 32'(f), 32'hFFFF);

    // Asynchronous reset while holding a result in DONE
    #3;
    rst_n = 1'b0;
    #1;
    chk_reset_outputs("async_rst");
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;

    do_op("xor", 16'hF0F0, 16'hFF00, 4'b0110, 1'b1, 1'b1, 1'b1);
    chk("xor.f_const", 32'(f), 32'h0FF0);
    do_op("pass0", 16'h0000, 16'h5A5A, 4'b0000, 1'b0, 1'b0, 1'b1);
    chk("pass0.f_const", 32'(f), 32'h0000);

    // Backpressure: result held while a new request waits
    do_op("bp", 16'hA5C3, 16'h1234, 4'b1001, 1'b0, 1'b1, 1'b0);
    bp_exp = ref_alu(16'hA5C3, 16'h1234, 4'b1001, 1'b0, 1'b1);
    a = 16'h0F0F; b = 16'h00F0; s = 4'b0110; m = 1'b1; c_in = 1'b0; in_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      chk("bp.hold_f",         32'(f),         32'(bp_exp[WIDTH-1:0]));
      chk("bp.hold_c_out",     32'(c_out),     32'(bp_exp[WIDTH]));
      chk("bp.hold_out_valid", 32'(out_valid), 32'd1);
      chk("bp.hold_in_ready",  32'(in_ready),  32'd0);
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    chk("bp.release_in_ready",  32'(in_ready),  32'd1);
    chk("bp.release_out_valid", 32'(out_valid), 32'd0);
    chk("bp.release_f",         32'(f),         32'(bp_exp[WIDTH-1:0]));
    do_op("bp_new", 16'h0F0F, 16'h00F0, 4'b0110, 1'b1, 1'b0, 1'b1);

    // Reset during the second RUN cycle discards the operation
    a = 16'h00FF; b = 16'h0001; s = 4'b1001; m = 1'b0; c_in = 1'b0; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(posedge clk); #1;
    #3;
    rst_n = 1'b0;
    #1;
    chk_reset_outputs("run_rst");
    @(posedge clk); #1;
    rst_n = 1'b1;
    repeat (6) @(posedge clk);
    #1;
    chk("run_rst.no_valid", 32'(out_valid), 32'd0);
    chk("run_rst.no_f",     32'(f),         32'd0);
    do_op("rerun", 16'h00FF, 16'h0001, 4'b1001, 1'b0, 1'b0, 1'b1);
    chk("rerun.f_const", 32'(f), 32'h0100);
    chk("rerun.c_const", 32'(c_out), 32'd0);

    for (int i = 0; i < 48; i++) begin
      do_op("rnd", WIDTH'($urandom), WIDTH'($urandom), 4'(i % 16), 1'(i / 16 % 2 == 1),
            1'($urandom), 1'b1);
    end
    do_op("rnd_eq", 16'hBEEF, 16'hBEEF, 4'($urandom), 1'($urandom), 1'($urandom), 1'b1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/ula_fatiada.md
# ula_fatiada

Multi-cycle, width-parametrised successor of the team's 4-bit 74181-style ALU. Captures WIDTH-bit operands through a valid/ready handshake and evaluates one 4-bit slice per clock, LSB slice first, chaining the carry through a register between slices. The ripple behaviour of cascaded 74181 parts is preserved in a single small datapath. It sits between the operand register file and the result writeback stage.

## Interface
- WIDTH, 16, operand/result width in bits; multiple of 4, ≥ 4. N = WIDTH/4 is the slice count.
- clk  in  1  sole clock, rising edge.
- rst_n  in  1  reset, asynchronous, active-low.
- in_valid  in  1  request valid.
- in_ready  out  1  block can accept a request.
- a, b  in  WIDTH  operands.
- s  in  4  function select {S3,S2,S1,S0}.
- m  in  1  1 = logic, 0 = arithmetic.
- c_in  in  1  carry into slice 0; active-high.
- out_valid  out  1  result valid.
- out_ready  in  1  consumer accepts result.
- f  out  WIDTH  result.
- c_out  out  1  carry out of slice N-1; 0 in logic mode.
- a_eq_b  out  1  (a == b) over full WIDTH, of captured operands.
- zero  out  1  f == 0.

## Operation
- States: IDLE, RUN, DONE.
- IDLE:
  - in_ready = 1.
  - On in_valid: capture a, b, s, m, c_in; set slice index i = 0; carry register = c_in; go to RUN.
- RUN:
  - in_ready = 0.
  - Each cycle, compute slice i from captured A[4i+3:4i] and B[4i+3:4i]:
    - Write its 4 bits into the internal result register.
    - Carry register ← 5-bit sum bit 4 (arithmetic mode) or 0 (logic mode).
    - i ← i+1.
  - After slice N-1, load the outputs f, c_out, a_eq_b and zero from the internal state; go to DONE.
- DONE:
  - out_valid = 1; in_ready = 0; in_valid ignored.
  - On out_ready: go to IDLE.
  - Outputs hold their values until the next RUN→DONE load.
- Logic mode, per bit, for s = 0..15:
  - 0: ~A
  - 1: ~(A|B)
  - 2: ~A&B
  - 3: 0
  - 4: ~(A&B)
  - 5: ~B
  - 6: A^B
  - 7: A&~B
  - 8: ~A|B
  - 9: ~(A^B)
  - 10: B
  - 11: A&B
  - 12: all ones
  - 13: A|~B
  - 14: A|B
  - 15: A
- Arithmetic mode:
  - Each slice computes X + Y + carry in 5 bits. K = 4'b1111, which yields full-width −1 when chained.
  - (X, Y) for s = 0..15:
    - 0: (A, 0)
    - 1: (A|B, 0)
    - 2: (A|~B, 0)
    - 3: (K, 0)
    - 4: (A, A&~B)
    - 5: (A|B, A&~B)
    - 6: (A, ~B), i.e. A−B−1+c_in
    - 7: (A&~B, K)
    - 8: (A, A&B)
    - 9: (A, B)
    - 10: (A|~B, A&B)
    - 11: (A&B, K)
    - 12: (A, A)
    - 13: (A|B, A)
    - 14: (A|~B, A)
    - 15: (A, K)
- Full-width result equals the WIDTH-bit function mod 2^WIDTH. c_out is the true carry out of bit WIDTH-1.

## Timing
- Reset values (async assert, any state): state IDLE, in_ready 1, out_valid 0, f 0, c_out 0, a_eq_b 0, zero 0. Slice index and carry register are also cleared.
- Reset deassertion is synchronised by the caller; the first accept can occur at the first rising edge with rst_n high.
- Latency: with the request accepted at edge k, slices are computed at edges k+1..k+N. out_valid rises after edge k+N, so N cycles from accept to valid.
- Throughput: one operation per N+2 cycles minimum (accept, N slices, release), with out_ready held high.
- in_valid while in RUN or DONE: ignored, and no capture occurs. The requester holds its request until it sees in_ready.
- out_ready while not in DONE: ignored.
- Reset asserted mid-RUN or mid-DONE:
  - The operation is discarded and no partial result reaches f.
  - All outputs return to reset values immediately.
- The slice index wraps to 0 only via IDLE capture; it never exceeds N-1.

## Test plan
- Reset: assert rst_n=0 mid-cycle -> in_ready=1, out_valid=0, f=0, c_out=0, a_eq_b=0, zero=0 without waiting for clk.
- WIDTH=16, m=0, s=1001, a=0xFFFF, b=0x0001, c_in=0 -> f=0x0000, c_out=1, zero=1, a_eq_b=0; out_valid exactly 4 cycles after accept.
- m=0, s=0110, c_in=1, a=b=0x1234 -> f=0x0000, c_out=1, a_eq_b=1, zero=1. Repeat with c_in=0 -> f=0xFFFF, c_out=0, zero=0.
- m=1, s=0110, a=0xF0F0, b=0xFF00, c_in=1 -> f=0x0FF0, c_out=0. Then m=0, s=0000, a=0x0000, c_in=0 -> f=0x0000, c_out=0.
- Backpressure: hold out_ready=0 for 3 cycles after out_valid while driving in_valid=1 with new operands -> f/flags stable, in_ready=0, no capture. out_ready=1 -> IDLE, then the new request is accepted.
- Reset at 2nd RUN cycle of s=1001, a=0x00FF, b=0x0001 -> outputs return to reset values. Re-issue the same request after release -> f=0x0100, c_out=0.
